// File: rtl/led_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_buffer
// Brief    : Double-buffered pixel memory for the LED driver. Two read ports
//            serve the front bank; CPU writes and bulk fills go to the back bank.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_buffer #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clkIn,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pixelAddress0,
   input  logic [ADDR_WIDTH-1:0] pixelAddress1,
   output logic [DATA_WIDTH-1:0] pixel0,
   output logic [DATA_WIDTH-1:0] pixel1,
   input  logic                  done,
   input  logic                  wrEn,
   input  logic [ADDR_WIDTH-1:0] wrAddr,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic                  swapReq,
   output logic                  swapPending,
   input  logic                  fillReq,
   input  logic [DATA_WIDTH-1:0] fillColor,
   output logic                  busy,
   output logic                  frontSel,
   output logic [7:0]            swapCount
);

   localparam int                    c_DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_fillCnt;
   logic [DATA_WIDTH-1:0] r_fillColor;
   logic                  r_busy;
   logic                  r_frontSel;
   logic                  r_swapPending;
   logic [7:0]            r_swapCount;
   logic [DATA_WIDTH-1:0] r_pixel0;
   logic [DATA_WIDTH-1:0] r_pixel1;

   logic [DATA_WIDTH-1:0] r_bankA [c_DEPTH];
   logic [DATA_WIDTH-1:0] r_bankB [c_DEPTH];

   logic                  w_swap;
   logic                  w_wrEn;
   logic [ADDR_WIDTH-1:0] w_wrAddr;
   logic [DATA_WIDTH-1:0] w_wrData;
   logic                  w_weA;
   logic                  w_weB;

   // Swaps only at frame boundaries and never while the back bank is being filled
   assign w_swap = done & (r_swapPending | swapReq) & (r_state == ST_IDLE);

   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_fillCnt     <= '0;
         r_fillColor   <= '0;
         r_busy        <= 1'b0;
         r_frontSel    <= 1'b0;
         r_swapPending <= 1'b0;
         r_swapCount   <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (fillReq) begin
                  r_fillColor <= fillColor;
                  r_fillCnt   <= '0;
                  r_state     <= ST_FILL;
                  r_busy      <= 1'b1;
               end
            end
            ST_FILL: begin
               r_fillCnt <= r_fillCnt + 1'b1;
               if (r_fillCnt == c_LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_swap) begin
            r_frontSel    <= ~r_frontSel;
            r_swapPending <= 1'b0;
            r_swapCount   <= r_swapCount + 8'd1;
         end else if (swapReq) begin
            r_swapPending <= 1'b1;
         end
      end
   end

   // Single back-bank write port shared by the fill engine and the CPU
   always_comb begin
      w_wrEn   = 1'b0;
      w_wrAddr = wrAddr;
      w_wrData = wrData;
      if (r_state == ST_FILL) begin
         w_wrEn   = 1'b1;
         w_wrAddr = r_fillCnt;
         w_wrData = r_fillColor;
      end else if (wrEn) begin
         w_wrEn = 1'b1;
      end
   end

   assign w_weA = w_wrEn &  r_frontSel;
   assign w_weB = w_wrEn & ~r_frontSel;

   always_ff @(posedge clkIn) begin
      if (w_weA) begin
         r_bankA[w_wrAddr] <= w_wrData;
      end
      if (w_weB) begin
         r_bankB[w_wrAddr] <= w_wrData;
      end
   end

   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         r_pixel0 <= '0;
         r_pixel1 <= '0;
      end else begin
         r_pixel0 <= r_frontSel ? r_bankB[pixelAddress0] : r_bankA[pixelAddress0];
         r_pixel1 <= r_frontSel ? r_bankB[pixelAddress1] : r_bankA[pixelAddress1];
      end
   end

   assign pixel0      = r_pixel0;
   assign pixel1      = r_pixel1;
   assign busy        = r_busy;
   assign frontSel    = r_frontSel;
   assign swapPending = r_swapPending;
   assign swapCount   = r_swapCount;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_buffer
// Brief    : Scoreboard bench for led_frame_buffer against an image-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_frame_buffer;

   localparam int AW    = 11;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clkIn = 1'b0;
   logic          rst   = 1'b0;
   logic [AW-1:0] pixelAddress0 = '0;
   logic [AW-1:0] pixelAddress1 = '0;
   logic [DW-1:0] pixel0;
   logic [DW-1:0] pixel1;
   logic          done = 1'b0;
   logic          wrEn = 1'b0;
   logic [AW-1:0] wrAddr = '0;
   logic [DW-1:0] wrData = '0;
   logic          swapReq = 1'b0;
   logic          swapPending;
   logic          fillReq = 1'b0;
   logic [DW-1:0] fillColor = '0;
   logic          busy;
   logic          frontSel;
   logic [7:0]    swapCount;

   always #5 clkIn = ~clkIn;

   led_frame_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clkIn(clkIn), .rst(rst),
      .pixelAddress0(pixelAddress0), .pixelAddress1(pixelAddress1),
      .pixel0(pixel0), .pixel1(pixel1),
      .done(done), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .swapReq(swapReq), .swapPending(swapPending),
      .fillReq(fillReq), .fillColor(fillColor),
      .busy(busy), .frontSel(frontSel), .swapCount(swapCount)
   );

   typedef struct {
      bit         c0;
      bit         c1;
      logic [7:0] p0;
      logic [7:0] p1;
      bit         fs;
      bit         pend;
      bit         bsy;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Model: two images, which one is shown, and how many fill cycles remain
   logic [7:0] mem [2][DEPTH];
   bit         kn  [2][DEPTH];
   int         mFront = 0;
   int         mPend  = 0;
   int         mCnt   = 0;
   int         mFill  = 0;
   int         mFillBank = 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clkIn);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c0) chk("pixel0", pixel0, e.p0);
            if (e.c1) chk("pixel1", pixel1, e.p1);
            chk("frontSel", frontSel, e.fs);
            chk("swapPending", swapPending, e.pend);
            chk("busy", busy, e.bsy);
            chk("swapCount", swapCount, e.cnt);
         end
      end
   end

   task automatic step(input bit d, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit sr, input bit fr, input logic [DW-1:0] fc,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      exp_t e;
      int   b;
      bit   idle;
      bit   sw;
      @(negedge clkIn);
      done = d; wrEn = we; wrAddr = wa; wrData = wd;
      swapReq = sr; fillReq = fr; fillColor = fc;
      pixelAddress0 = a0; pixelAddress1 = a1;

      e.c0 = kn[mFront][a0];
      e.p0 = mem[mFront][a0];
      e.c1 = kn[mFront][a1];
      e.p1 = mem[mFront][a1];

      b    = 1 - mFront;
      idle = (mFill == 0);
      sw   = d && (mPend != 0 || sr) && idle;
      if (we && idle) begin
         mem[b][wa] = wd;
         kn[b][wa]  = 1'b1;
      end
      if (sw) begin
         mFront = 1 - mFront;
         mPend  = 0;
         mCnt   = (mCnt + 1) % 256;
      end else if (sr) begin
         mPend = 1;
      end
      if (!idle) begin
         mFill--;
      end else if (fr) begin
         mFill     = DEPTH;
         mFillBank = 1 - mFront;
         for (int i = 0; i < DEPTH; i++) begin
            mem[mFillBank][i] = fc;
            kn[mFillBank][i]  = 1'b1;
         end
      end

      e.fs   = (mFront != 0);
      e.pend = (mPend != 0);
      e.bsy  = (mFill > 0);
      e.cnt  = 8'(mCnt);
      q.push_back(e);
   endtask

   function automatic logic [AW-1:0] ra();
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, ra(), 8'h00, 0, 0, 8'h00, ra(), ra());
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      step(0, 0, ra(), 8'h00, 0, 0, 8'h00, a0, a1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pixel0"}, pixel0, 8'h00);
      chk({tag, "_pixel1"}, pixel1, 8'h00);
      chk({tag, "_frontSel"}, frontSel, 1'b0);
      chk({tag, "_swapPending"}, swapPending, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_swapCount"}, swapCount, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clkIn);
      rst = 1'b0;
      done = 0; wrEn = 0; swapReq = 0; fillReq = 0;
      #1;
      check_reset_vals("rst_now");
      if (mFill > 0) begin
         for (int i = 0; i < DEPTH; i++) kn[mFillBank][i] = 1'b0;
      end
      mFront = 0; mPend = 0; mCnt = 0; mFill = 0;
      @(posedge clkIn);
      #1;
      check_reset_vals("rst_held");
      @(negedge clkIn);
      rst = 1'b1;
   endtask

   initial begin : main
      int n;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < DEPTH; i++) begin
            kn[b][i]  = 1'b0;
            mem[b][i] = 8'h00;
         end
      do_reset();

      // Fill 0x15, swap, read corners
      step(0, 0, '0, 8'h00, 0, 1, 8'h15, ra(), ra());
      idle_n(DEPTH);
      step(0, 0, '0, 8'h00, 1, 0, 8'h00, ra(), ra());
      step(1, 0, '0, 8'h00, 0, 0, 8'h00, ra(), ra());
      rd(11'd0, 11'd0);
      rd(11'd1023, 11'd2047);
      rd(11'd2047, 11'd1023);
      rd(11'd0, 11'd2047);

      // Back-bank write invisible until swapped in
      step(0, 1, 11'd5, 8'h2A, 0, 0, 8'h00, 11'd5, 11'd5);
      rd(11'd5, 11'd5);
      step(0, 0, '0, 8'h00, 1, 0, 8'h00, 11'd5, 11'd4);
      step(1, 0, '0, 8'h00, 0, 0, 8'h00, 11'd5, 11'd5);
      rd(11'd5, 11'd5);
      rd(11'd5, 11'd6);

      // Pending swap waits for done
      step(0, 0, '0, 8'h00, 1, 0, 8'h00, ra(), ra());
      idle_n(100);
      step(1, 0, '0, 8'h00, 0, 0, 8'h00, ra(), ra());

      // Fill 0x3F with a swap request and a done mid-fill, plus a dropped write
      step(0, 0, '0, 8'h00, 0, 1, 8'h3F, ra(), ra());
      step(0, 0, '0, 8'h00, 1, 0, 8'h00, ra(), ra());
      idle_n(497);
      step(1, 0, '0, 8'h00, 0, 0, 8'h00, ra(), ra());
      step(0, 1, 11'd7, 8'h01, 0, 0, 8'h00, ra(), ra());
      idle_n(DEPTH - 500);
      step(1, 0, '0, 8'h00, 0, 0, 8'h00, ra(), ra());
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));
      rd(11'd7, 11'd7);

      // Swap on the same edge a fill is accepted
      step(0, 0, '0, 8'h00, 1, 0, 8'h00, ra(), ra());
      step(1, 1, 11'd9, 8'h33, 0, 1, 8'h0C, ra(), ra());
      idle_n(DEPTH);
      step(1, 0, '0, 8'h00, 1, 0, 8'h00, 11'd9, 11'd9);
      rd(11'd9, ra());
      idle_n(20);

      // Swap counter wraps
      n = 256 - mCnt;
      for (int i = 0; i < n + 3; i++) begin
         step(0, ($urandom % 2) == 0, ra(), 8'($urandom), 1, 0, 8'h00, ra(), ra());
         step(1, 0, '0, 8'h00, 0, 0, 8'h00, ra(), ra());
      end

      // Randomized traffic
      for (int i = 0; i < 7000; i++)
         step(($urandom % 6) == 0, ($urandom % 3) == 0, ra(), 8'($urandom),
              ($urandom % 10) == 0, ($urandom % 1500) == 0, 8'($urandom), ra(), ra());
      idle_n(DEPTH + 2);

      // Reset in the middle of a fill, then recover
      step(0, 0, '0, 8'h00, 1, 1, 8'h2D, ra(), ra());
      idle_n(300);
      do_reset();
      step(0, 0, '0, 8'h00, 0, 1, 8'h11, ra(), ra());
      idle_n(DEPTH);
      step(1, 0, '0, 8'h00, 1, 0, 8'h00, ra(), ra());
      for (int i = 0; i < 16; i++) rd(ra(), ra());
      idle_n(2);

      @(negedge clkIn);
      @(negedge clkIn);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
